// File: rtl/shift_pkg.sv
// Shared constants, opcode and state enums for the sequential shift/rotate/swap unit.
package shift_pkg;

  localparam int DATA_W = 20;
  localparam int AMT_W  = 5;

  typedef enum logic [2:0] {
    SHR  = 3'd0,
    SHL  = 3'd1,
    ROR  = 3'd2,
    ROL  = 3'd3,
    SWAP = 3'd4
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } shift_state_t;

  // Encodings 5-7 are reserved and reported through out_err.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

endpackage

// File: rtl/shift_seq_unit_if.sv
// Request/response handshake bundle between the issue logic (master) and shift_seq_unit (slave).
interface shift_seq_unit_if;
  import shift_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_data_a;
  logic [DATA_W-1:0] in_data_b;
  logic [AMT_W-1:0]  in_amount;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result_a;
  logic [DATA_W-1:0] out_result_b;
  logic              out_err;

  modport master (
    output in_valid, in_op, in_data_a, in_data_b, in_amount, out_ready,
    input  in_ready, out_valid, out_result_a, out_result_b, out_err
  );

  modport slave (
    input  in_valid, in_op, in_data_a, in_data_b, in_amount, out_ready,
    output in_ready, out_valid, out_result_a, out_result_b, out_err
  );

endinterface

// File: rtl/shift_step.sv
// One iteration of the shift/rotate datapath: advances the working value by 1 bit,
// or by 4 bits when step4 is set.
module shift_step
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] work,
  input  shift_op_t         op,
  input  logic              step4,
  output logic [DATA_W-1:0] work_nxt
);

  always_comb begin
    work_nxt = work;
    case (op)
      SHR: work_nxt = step4 ? {4'b0000, work[DATA_W-1:4]} : {1'b0, work[DATA_W-1:1]};
      SHL: work_nxt = step4 ? {work[DATA_W-5:0], 4'b0000} : {work[DATA_W-2:0], 1'b0};
      ROR: work_nxt = step4 ? {work[3:0], work[DATA_W-1:4]} : {work[0], work[DATA_W-1:1]};
      ROL: work_nxt = step4 ? {work[DATA_W-5:0], work[DATA_W-1:DATA_W-4]}
                            : {work[DATA_W-2:0], work[DATA_W-1]};
      default: work_nxt = work;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Iterative shift/rotate/swap execute stage with valid/ready request and result handshakes.
// Define SHIFT_SEQ_STEP4_EN to let BUSY advance 4 bits per cycle while at least 4 remain.
module shift_seq_unit
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  shift_seq_unit_if.slave  bus,
  output logic             busy
);

  shift_state_t      state, state_nxt;
  shift_op_t         op_q;
  logic [DATA_W-1:0] work_q;
  logic [DATA_W-1:0] work_step;
  logic [DATA_W-1:0] pend_b_q;
  logic              pend_err_q;
  logic [AMT_W-1:0]  cnt_q;
  logic [AMT_W-1:0]  cnt_dec;
  logic              step4;
  logic [DATA_W-1:0] res_a_q;
  logic [DATA_W-1:0] res_b_q;
  logic              err_q;

`ifdef SHIFT_SEQ_STEP4_EN
  assign step4 = (cnt_q >= AMT_W'(4));
`else
  assign step4 = 1'b0;
`endif

  assign cnt_dec = step4 ? AMT_W'(4) : AMT_W'(1);

  shift_step u_step (
    .work     (work_q),
    .op       (op_q),
    .step4    (step4),
    .work_nxt (work_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)     state_nxt = BUSY;
      BUSY:    if (cnt_q == '0)      state_nxt = DONE;
      DONE:    if (bus.out_ready)    state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
      end
      DONE:    bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // The working register iterates privately; the visible result registers only
  // change on the BUSY->DONE edge so consumers see the last delivered values otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= SHR;
      work_q     <= '0;
      pend_b_q   <= '0;
      pend_err_q <= 1'b0;
      cnt_q      <= '0;
      res_a_q    <= '0;
      res_b_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= SHR;
            cnt_q      <= '0;
            pend_b_q   <= '0;
            pend_err_q <= 1'b0;
            if (!op_legal(bus.in_op)) begin
              work_q     <= bus.in_data_a;
              pend_err_q <= 1'b1;
            end else if (bus.in_op == SWAP) begin
              work_q   <= bus.in_data_b;
              pend_b_q <= bus.in_data_a;
            end else if (bus.in_amount >= AMT_W'(DATA_W)) begin
              work_q <= '0;
            end else begin
              work_q <= bus.in_data_a;
              cnt_q  <= bus.in_amount;
              op_q   <= shift_op_t'(bus.in_op);
            end
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            work_q <= work_step;
            cnt_q  <= cnt_q - cnt_dec;
          end else begin
            res_a_q <= work_q;
            res_b_q <= pend_b_q;
            err_q   <= pend_err_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_result_a = res_a_q;
  assign bus.out_result_b = res_b_q;
  assign bus.out_err      = err_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: directed cases plus randomized requests
// compared against an arithmetic reference model (honours SHIFT_SEQ_STEP4_EN for latency).
module tb_shift_seq_unit;

  logic clk;
  logic rst_n;
  logic busy;
  int   checks;
  int   fails;

  logic [19:0] prev_a;
  logic [19:0] prev_b;
  logic        prev_err;

  shift_seq_unit_if bus ();

  shift_seq_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result computed directly from the operation's arithmetic meaning.
  function automatic logic [19:0] refA(input logic [2:0] op, input logic [19:0] a,
                                       input logic [19:0] b, input logic [4:0] amt);
    longint unsigned av;
    longint unsigned r;
    int n;
    av = 64'(a);
    n  = int'(amt);
    r  = 0;
    if (op <= 3'd3 && n >= 20) return 20'h0;
    case (op)
      3'd0:    r = av >> n;
      3'd1:    r = av << n;
      3'd2:    r = (av >> n) | (av << (20 - n));
      3'd3:    r = (av << n) | (av >> (20 - n));
      3'd4:    r = 64'(b);
      default: r = av;
    endcase
    return r[19:0];
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [4:0] amt);
    int n;
    n = int'(amt);
    if (op > 3'd3 || n >= 20) return 1;
`ifdef SHIFT_SEQ_STEP4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [19:0] a, input logic [19:0] b,
                               input logic [4:0] amt, input int hold);
    logic [19:0] exp_a;
    logic [19:0] exp_b;
    logic        exp_err;
    int          cycles;
    exp_a   = refA(op, a, b, amt);
    exp_b   = (op == 3'd4) ? a : 20'h0;
    exp_err = (op > 3'd4);

    @(negedge clk);
    checkOutput("idle_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_data_a = a;
    bus.in_data_b = b;
    bus.in_amount = amt;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_data_a = 20'($urandom);
    bus.in_data_b = 20'($urandom);
    bus.in_amount = 5'($urandom);
    bus.in_op     = 3'($urandom);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);

    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 100) begin
      checkOutput("held_a", 32'(bus.out_result_a), 32'(prev_a));
      checkOutput("held_b", 32'(bus.out_result_b), 32'(prev_b));
      checkOutput("held_err", 32'(bus.out_err), 32'(prev_err));
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      cycles++;
    end
    bus.out_ready = 1'b0;

    checkOutput("latency", 32'(cycles), 32'(refLatency(op, amt)));
    checkOutput("result_a", 32'(bus.out_result_a), 32'(exp_a));
    checkOutput("result_b", 32'(bus.out_result_b), 32'(exp_b));
    checkOutput("err", 32'(bus.out_err), 32'(exp_err));
    checkOutput("done_ready", 32'(bus.in_ready), 32'd0);

    for (int i = 0; i < hold; i++) begin
      bus.in_valid  = (i % 2 == 0);
      bus.in_op     = 3'($urandom);
      bus.in_data_a = 20'($urandom);
      bus.in_amount = 5'($urandom);
      @(posedge clk);
      #1;
      checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("hold_a", 32'(bus.out_result_a), 32'(exp_a));
      checkOutput("hold_b", 32'(bus.out_result_b), 32'(exp_b));
      checkOutput("hold_err", 32'(bus.out_err), 32'(exp_err));
    end
    bus.in_valid = 1'b0;

    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("post_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("post_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_a", 32'(bus.out_result_a), 32'(exp_a));
    prev_a   = exp_a;
    prev_b   = exp_b;
    prev_err = exp_err;
  endtask

  task automatic applyResetMidBusy();
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_op     = 3'd1;
    bus.in_data_a = 20'hFFFFF;
    bus.in_data_b = 20'h0;
    bus.in_amount = 5'd15;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_a", 32'(bus.out_result_a), 32'd0);
    checkOutput("rst_b", 32'(bus.out_result_b), 32'd0);
    checkOutput("rst_err", 32'(bus.out_err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_a   = 20'h0;
    prev_b   = 20'h0;
    prev_err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_idle_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_idle_valid", 32'(bus.out_valid), 32'd0);
    end
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    prev_a        = 20'h0;
    prev_b        = 20'h0;
    prev_err      = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_data_a = 20'h0;
    bus.in_data_b = 20'h0;
    bus.in_amount = 5'd0;
    bus.out_ready = 1'b0;
    #12;
    checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_a", 32'(bus.out_result_a), 32'd0);
    checkOutput("reset_b", 32'(bus.out_result_b), 32'd0);
    checkOutput("reset_err", 32'(bus.out_err), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with in_valid low must not move the unit.
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("idle_stays", 32'(busy), 32'd0);
    end

    applyStimulus(3'd2, 20'h00001, 20'h0, 5'd1, 0);
    applyStimulus(3'd3, 20'h80001, 20'h0, 5'd4, 0);
    applyStimulus(3'd0, 20'hFFFFF, 20'h0, 5'd19, 0);
    applyStimulus(3'd1, 20'hFFFFF, 20'h0, 5'd25, 0);
    applyStimulus(3'd4, 20'h12345, 20'hABCDE, 5'd7, 0);
    applyStimulus(3'd4, 20'h0F0F0, 20'h0F0F0, 5'd3, 0);
    applyStimulus(3'd2, 20'hABCDE, 20'h0, 5'd20, 0);
    applyStimulus(3'd3, 20'h12345, 20'h0, 5'd0, 3);
    applyStimulus(3'd6, 20'h5A5A5, 20'h11111, 5'd9, 10);
    applyStimulus(3'd1, 20'h00003, 20'h0, 5'd18, 10);

    applyResetMidBusy();

    for (int i = 0; i < 60; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 20'($urandom), 20'($urandom),
                    5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
        checkOutput("gap_ready", 32'(bus.in_ready), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Sequential execute stage that feeds the 20-bit shift/rotate/swap datapath results to writeback.
- Accepts one shift/rotate/swap request per transaction over a valid/ready handshake.
- Computes the result iteratively, one bit per cycle, and holds the result until the consumer takes it.
- Replaces wide combinational shifters in the ALU issue path with a small area-cheap unit.

Parameters:
- DATA_W, 20, datapath width; only 20 is verified.
- AMT_W, 5, shift-amount width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request (high only in IDLE).
- in_op  in  3  operation: 0=SHR, 1=SHL, 2=ROR, 3=ROL, 4=SWAP, 5-7 illegal.
- in_data_a  in  DATA_W  primary operand.
- in_data_b  in  DATA_W  second operand (SWAP only).
- in_amount  in  AMT_W  shift/rotate count.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result_a  out  DATA_W  shifted/rotated value, or swapped data_b.
- out_result_b  out  DATA_W  swapped data_a; 0 for non-SWAP ops.
- out_err  out  1  illegal opcode flag, valid with out_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - out_valid=0, out_result_a=0, out_result_b=0, out_err=0, busy=0.
  - Internal count=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch op/data/amount and go to BUSY.
  - BUSY: each edge, if cnt!=0, apply a one-bit step to the working register and do cnt-=1. If cnt==0, go to DONE.
  - DONE: out_valid=1 and outputs held stable. On out_ready, go to IDLE. in_ready=0 throughout.
- Load rules at accept:
  - SHR/SHL/ROR/ROL with amount<20: working=data_a, cnt=amount.
  - SHR/SHL/ROR/ROL with amount>=20: working=0, cnt=0. The result is 0 for rotates as well as shifts, matching the combinational units.
  - SWAP: result_a=data_b, result_b=data_a, cnt=0. This applies unconditionally, including when the operands are equal.
  - Illegal op: result_a=data_a, result_b=0, out_err=1, cnt=0.
- Step semantics:
  - SHR: logical, zero fill at bit 19.
  - SHL: zero fill at bit 0.
  - ROR: bit0→bit19.
  - ROL: bit19→bit0.
- Latency from accept edge to out_valid high: amount+1 cycles. It is 1 cycle for amount 0, amount>=20, SWAP and illegal ops.
- Back-to-back operation:
  - A new request is accepted no earlier than the cycle after the DONE handshake.
  - Throughput is 1 request per latency+2 cycles.
- Outputs while not DONE: out_result_a/b and out_err retain the last delivered values.
- Reset mid-BUSY or mid-DONE: the operation is discarded and the result is never presented.
- in_valid deasserted in IDLE: no state change.
- out_ready high outside DONE: ignored.

Optional Feature:
- Macro: SHIFT_SEQ_STEP4_EN.
- Defined:
  - In BUSY, when cnt>=4, step by 4 bits and do cnt-=4; otherwise step by 1.
  - Latency becomes floor(amount/4)+(amount%4)+1.
  - Results are identical to the undefined case.
- Undefined: single-bit steps only, with no 4-bit step logic synthesized.

Decomposition:
- Package shift_pkg holds:
  - DATA_W=20 and AMT_W=5 constants.
  - Opcode enum shift_op_t (SHR, SHL, ROR, ROL, SWAP).
  - State enum shift_state_t (IDLE, BUSY, DONE).
- Sub-module shift_step: combinational, computes (working, op, step4) → next working. It is instantiated once and is the only place the step semantics live.

Test Plan:
- ROR data_a=0x00001, amount=1: result_a=0x80000, result_b=0, out_valid 2 cycles after accept.
- ROL data_a=0x80001, amount=4: result_a=0x00018, latency 5. With SHIFT_SEQ_STEP4_EN, latency 2.
- SHR data_a=0xFFFFF, amount=19: result_a=0x00001, latency 20. SHL amount=25: result_a=0, latency 1.
- SWAP a=0x12345, b=0xABCDE: result_a=0xABCDE, result_b=0x12345, latency 1. Repeat with a=b=0x0F0F0, expecting both results to equal 0x0F0F0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - Result must be stable and in_ready=0 throughout.
  - in_valid pulses in that window must not be accepted.
  - op=6 must give out_err=1 and result_a=data_a.
- Assert rst_n low mid-BUSY on SHL amount=15.
  - All outputs go to 0 immediately.
  - After release, in_ready=1 and out_valid stays 0 until a new request completes.
